imem_arbiter: RTL and testbench

//  - Shares the single combinational read port of the instruction memory between two requesters.

---
 rtl/imem_arbiter_pkg.sv | 19 +
 rtl/imem_arbiter_rr_pick2.sv | 19 +
 rtl/imem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_imem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM state encodings,
// requester port ids and the address-validity helper.
package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DBG   = 1'b1;

  // A word address is bad if it is not word aligned or points past the memory.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/imem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins; when both request,
// ptr names the favoured port. Purely combinational, grants one-hot or zero.
module rr_pick2
  import imem_arbiter_pkg::*;
(
  input  logic v0,
  input  logic v1,
  input  logic ptr,
  output logic g0,
  output logic g1
);

  // Grant selection
  always_comb begin
    g0 = v0 & (~v1 | (ptr == PORT_FETCH));
    g1 = v1 & (~v0 | (ptr == PORT_DBG));
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the combinational imem read port between CPU fetch (port 0) and a
// debug master (port 1). One transaction in flight: IDLE -> READ -> RESP.
// Optional grant counters are built when IMEM_ARB_STATS_EN is defined.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int DEPTH = 256
`ifdef IMEM_ARB_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid0,
  output logic        req_ready0,
  input  logic [31:0] req_addr0,
  output logic        rsp_valid0,
  input  logic        rsp_ready0,
  output logic [31:0] rsp_data0,
  output logic        rsp_err0,
  input  logic        req_valid1,
  output logic        req_ready1,
  input  logic [31:0] req_addr1,
  output logic        rsp_valid1,
  input  logic        rsp_ready1,
  output logic [31:0] rsp_data1,
  output logic        rsp_err1,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        busy
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  state_e      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic        lat_id_q, lat_id_d;
  logic [31:0] data0_q, data0_d, data1_q, data1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic        g0, g1;
  logic        rd_err;
  logic [31:0] rd_word;
  logic        owner_ready;

  rr_pick2 u_pick (
    .v0  (req_valid0),
    .v1  (req_valid1),
    .ptr (rr_ptr_q),
    .g0  (g0),
    .g1  (g1)
  );

  // Registered read result, zeroed on a bad address
  always_comb begin
    rd_err  = addr_err(lat_addr_q, DEPTH);
    rd_word = rd_err ? 32'd0 : imem_instr;
  end

  // Next-state and handshake logic; ready is only offered to the winner in IDLE
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lat_addr_d  = lat_addr_q;
    lat_id_d    = lat_id_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    err0_d      = err0_q;
    err1_d      = err1_q;
    req_ready0  = 1'b0;
    req_ready1  = 1'b0;
    owner_ready = (lat_id_q == PORT_DBG) ? rsp_ready1 : rsp_ready0;
    case (state_q)
      ST_IDLE: begin
        req_ready0 = g0;
        req_ready1 = g1;
        if (g0 | g1) begin
          lat_id_d   = g1 ? PORT_DBG : PORT_FETCH;
          lat_addr_d = g1 ? req_addr1 : req_addr0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (lat_id_q == PORT_DBG) begin
          data1_d = rd_word;
          err1_d  = rd_err;
        end else begin
          data0_d = rd_word;
          err0_d  = rd_err;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (owner_ready) begin
          rr_ptr_d = ~lat_id_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= PORT_FETCH;
      lat_addr_q <= 32'd0;
      lat_id_q   <= PORT_FETCH;
      data0_q    <= 32'd0;
      data1_q    <= 32'd0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lat_addr_q <= lat_addr_d;
      lat_id_q   <= lat_id_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

  // Output decode; imem_addr follows the latched address so it never glitches
  always_comb begin
    imem_addr  = lat_addr_q;
    busy       = (state_q != ST_IDLE);
    rsp_valid0 = (state_q == ST_RESP) && (lat_id_q == PORT_FETCH);
    rsp_valid1 = (state_q == ST_RESP) && (lat_id_q == PORT_DBG);
    rsp_data0  = data0_q;
    rsp_data1  = data1_q;
    rsp_err0   = err0_q;
    rsp_err1   = err1_q;
  end

`ifdef IMEM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Saturating per-port grant counters
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req_valid0 && req_ready0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + 1'b1;
    if (req_valid1 && req_ready1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter; grant counters are checked when
// IMEM_ARB_STATS_EN is defined (built with CNT_W=2).
module tb_imem_arbiter;

  localparam int DEPTH = 256;
`ifdef IMEM_ARB_STATS_EN
  localparam int CNT_W = 2;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][31:0]  req_addr, rsp_data;
  logic [31:0]       imem_addr, imem_instr;
  logic              busy;
`ifdef IMEM_ARB_STATS_EN
  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;
`endif

  logic [31:0] ram [DEPTH];
  int nvec = 0;
  int nerr = 0;
  int mcnt [2];

  always #5 clk = ~clk;

  // Combinational imem: out-of-window reads return a marker, low bits perturb data
  assign imem_instr = (imem_addr[31:10] == 22'd0)
                      ? (ram[imem_addr[9:2]] ^ {30'd0, imem_addr[1:0]})
                      : 32'hDEAD_BEEF;

  imem_arbiter #(
    .DEPTH(DEPTH)
`ifdef IMEM_ARB_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid0(req_valid[0]), .req_ready0(req_ready[0]), .req_addr0(req_addr[0]),
    .rsp_valid0(rsp_valid[0]), .rsp_ready0(rsp_ready[0]), .rsp_data0(rsp_data[0]),
    .rsp_err0(rsp_err[0]),
    .req_valid1(req_valid[1]), .req_ready1(req_ready[1]), .req_addr1(req_addr[1]),
    .rsp_valid1(rsp_valid[1]), .rsp_ready1(rsp_ready[1]), .rsp_data1(rsp_data[1]),
    .rsp_err1(rsp_err[1]),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .busy(busy)
`ifdef IMEM_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Reference model: an access is bad if misaligned or beyond DEPTH words
  function automatic logic exp_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return exp_err(a) ? 32'd0 : ram[a / 4];
  endfunction

  function automatic int sat(input int v);
`ifdef IMEM_ARB_STATS_EN
    return (v > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on port p; optionally the other port requests throughout
  task automatic do_txn(input int p, input logic [31:0] a, input int hold, input bit other);
    int n;
    logic [31:0] ed;
    logic        ee;
    ed = exp_data(a);
    ee = exp_err(a);
    req_valid[p] = 1'b1;
    req_addr[p]  = a;
    if (other) req_valid[1-p] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[p] && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("req_ready", req_ready[p], 1'b1);
    chk("req_ready_other", req_ready[1-p], 1'b0);
    tick();
    mcnt[p]++;
    req_valid[p] = 1'b0;
    #1;
    chk("busy_read", busy, 1'b1);
    chk("imem_addr", imem_addr, a);
    chk("rsp_valid_early", rsp_valid, 2'b00);
    tick();
    #1;
    chk("rsp_valid", rsp_valid, (p == 1) ? 2'b10 : 2'b01);
    chk("rsp_data", rsp_data[p], ed);
    chk("rsp_err", rsp_err[p], ee);
    for (int h = 0; h < hold; h++) begin
      tick();
      #1;
      chk("hold_valid", rsp_valid[p], 1'b1);
      chk("hold_data", rsp_data[p], ed);
      chk("hold_err", rsp_err[p], ee);
      chk("hold_no_ready", req_ready, 2'b00);
    end
    rsp_ready[p] = 1'b1;
    tick();
    rsp_ready[p] = 1'b0;
    #1;
    chk("rsp_drop", rsp_valid, 2'b00);
    chk("idle_after", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int exp_port, ngr, p, kind;
    int q_port [$];
    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    mcnt[0] = 0;
    mcnt[1] = 0;
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_addr[0] = 32'd0;
    req_addr[1] = 32'd0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_err", rsp_err, 2'b00);
    chk("rst_rsp_data0", rsp_data[0], 32'd0);
    chk("rst_rsp_data1", rsp_data[1], 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
`ifdef IMEM_ARB_STATS_EN
    chk("rst_cnt0", grant_cnt0, 0);
    chk("rst_cnt1", grant_cnt1, 0);
`endif

    // Both ports requesting every cycle: grants alternate from port 0
    tick();
    req_valid   = 2'b11;
    req_addr[0] = 32'h0;
    req_addr[1] = 32'h4;
    rsp_ready   = 2'b11;
    exp_port = 0;
    ngr = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("alt_grant", req_ready, (exp_port == 1) ? 2'b10 : 2'b01);
        q_port.push_back(exp_port);
        mcnt[exp_port]++;
        exp_port = 1 - exp_port;
        ngr++;
      end
      if (rsp_valid != 2'b00) begin
        if (q_port.size() == 0) begin
          chk("alt_rsp_unexpected", rsp_valid, 2'b00);
        end else begin
          p = q_port.pop_front();
          chk("alt_rsp_port", rsp_valid, (p == 1) ? 2'b10 : 2'b01);
          chk("alt_rsp_data", rsp_data[p], exp_data(32'(p * 4)));
        end
      end
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    chk("alt_grant_count", ngr, 4);
    chk("alt_rsp_count", q_port.size(), 0);
    tick();

    // Single fetch, then error cases on the debug port
    do_txn(0, 32'h8, 0, 1'b0);
    do_txn(1, 32'h6, 0, 1'b0);
    do_txn(1, 32'h400, 1, 1'b0);
    // Backpressure on port 0 while port 1 waits
    do_txn(0, 32'h10, 5, 1'b1);
    do_txn(1, 32'h14, 0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 16; t++) begin
      p = $urandom_range(0, 1);
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        2:    a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        default: a = 32'($urandom_range(DEPTH, 1 << 20)) << 2;
      endcase
      do_txn(p, a, $urandom_range(0, 3), 1'b0);
    end
`ifdef IMEM_ARB_STATS_EN
    chk("cnt0_mid", grant_cnt0, sat(mcnt[0]));
    chk("cnt1_mid", grant_cnt1, sat(mcnt[1]));
`endif

    // Reset while a debug read is in flight
    do_txn(0, 32'h20, 0, 1'b0);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h24;
    #1;
    chk("mid_req_ready1", req_ready[1], 1'b1);
    tick();
    req_valid[1] = 1'b0;
    #1;
    chk("mid_busy_read", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mcnt[0] = 0;
    mcnt[1] = 0;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_rsp_valid", rsp_valid, 2'b00);
    chk("mid_rsp_data1", rsp_data[1], 32'd0);
    chk("mid_rsp_err", rsp_err, 2'b00);
    chk("mid_imem_addr", imem_addr, 32'd0);
    req_valid   = 2'b11;
    req_addr[0] = 32'h28;
    req_addr[1] = 32'h2C;
    #1;
    chk("mid_fresh_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    tick();

    // Five port-0 grants for counter saturation
    for (int k = 0; k < 5; k++) do_txn(0, 32'(k * 4), 0, 1'b0);
`ifdef IMEM_ARB_STATS_EN
    chk("cnt0_sat", grant_cnt0, sat(mcnt[0]));
    chk("cnt1_zero", grant_cnt1, sat(mcnt[1]));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
